pong_score_keeper: RTL and testbench
====================================

# pong_score_keeper

Tracks both players' scores in two-digit BCD, detects the winning score and holds the game-over state until a new game is requested. Sits between the ball/collision logic, which issues point pulses, and the four nibble-to-seven-segment decoders that drive the score display. Each BCD digit output feeds one decoder directly.

## Interface
Parameters:
- WIN_SCORE, 11: decimal score that ends the game; legal range 1..99.
- BLINK_DIV, 25_000_000: clock cycles per blink half-period; used only when SCORE_BLINK_EN is defined.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- point_l  in  1  synchronous pulse; the left player scores. Every high cycle counts as one point.
- point_r  in  1  synchronous pulse; the right player scores.
- new_game  in  1  synchronous pulse; clears both scores and resumes play.
- l_tens, l_ones  out  4  left score BCD digits, 0..9 each.
- r_tens, r_ones  out  4  right score BCD digits, 0..9 each.
- game_over  out  1  high while in state OVER.
- winner  out  1  0 = left, 1 = right; valid only while game_over is high.
- digit_en  out  4  per-digit lit enable: [3]=l_tens, [2]=l_ones, [1]=r_tens, [0]=r_ones.

## Operation
- States: PLAY and OVER.
- Reset values: state PLAY; all digits 0; game_over 0; winner 0; digit_en 4'hF.
- PLAY:
  - point_l increments the left BCD pair. The ones digit runs 9→0 and carries into tens.
  - point_r increments the right pair in the same way.
- Simultaneous point_l and point_r: point_l wins. point_r is dropped that cycle.
- Win detection uses the next-state score. On the edge where a pair becomes WIN_SCORE, the score updates, state goes to OVER, and winner is set to the scoring side, all on that same edge.
- OVER:
  - point_l and point_r are ignored and scores are frozen.
  - new_game clears all digits and returns to PLAY. winner keeps its value but is don't-care.
- new_game in PLAY clears both scores and stays in PLAY.
- new_game has priority over any point pulse in the same cycle.
- Digits never exceed 9 and a pair never exceeds 99. WIN_SCORE ≤ 99 guarantees OVER is reached before overflow.
- The compare is done per BCD digit against elaboration-time constants WIN_TENS = WIN_SCORE/10 and WIN_ONES = WIN_SCORE%10. There is no binary score register.
- Reset asserted mid-game returns immediately to the reset values, independent of clk.

## Timing
- All outputs are registered.
- A pulse sampled on edge N is visible on the digit outputs after edge N, i.e. 1-cycle latency.
- game_over rises on the same edge as the final score update.
- new_game to cleared digits and game_over low: 1 cycle.
- No handshake. Upstream must produce one-cycle pulses; a held level scores once per cycle.

## Configuration
- SCORE_BLINK_EN defined: blinks the winner's digits while in OVER.
  - A phase counter of width $clog2(BLINK_DIV) runs only in OVER.
  - It loads 0 with phase=1 (lit) on the edge entering OVER, and toggles phase every BLINK_DIV cycles.
  - The winner's two digit_en bits equal phase; the loser's bits stay 1.
  - Leaving OVER restores digit_en to 4'hF on the same edge.
- SCORE_BLINK_EN undefined: no counter is built, digit_en is the constant 4'hF, and BLINK_DIV is unused.

## Structure
- Package pong_pkg holds:
  - the typedef game_state_t {PLAY, OVER};
  - the typedef bcd_t (logic [3:0]);
  - localparam BCD_MAX = 4'd9.
- One sub-module, bcd_pair_counter, instantiated twice:
  - inputs clk, rst_n, clr, inc;
  - outputs tens and ones;
  - clr has priority over inc.
- The top level contains the FSM, win compare, priority logic and optional blink counter.

## Test plan
- Reset: assert rst_n=0 mid-count at left=07 → all digits 0, game_over 0, digit_en 4'hF with no clock edge.
- Carry: 10 point_l pulses from reset → l_tens=1, l_ones=0 one cycle after the tenth pulse; right digits stay 0.
- Win: WIN_SCORE=11, 11 point_r pulses → r=11 with game_over=1 and winner=1 on the same edge. A further point_l leaves left=00.
- Collision: point_l and point_r high together at 03–04 → 04–04. new_game together with point_l → 00–00.
- Restart: in OVER, new_game pulse → next cycle all digits 0 and game_over 0; a following point_l gives left=01.
- Blink (SCORE_BLINK_EN, BLINK_DIV=4): left wins → digit_en=4'hF for 4 cycles, then 4'h3 for 4, then 4'hF. new_game → 4'hF next cycle.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and helpers for the pong score keeper.
// Holds the game states, the BCD digit type and the BCD increment helper.
package pong_pkg;

  typedef enum logic {
    PLAY = 1'b0,
    OVER = 1'b1
  } game_state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  // Two-digit BCD increment; holds at 99.
  function automatic logic [7:0] bcd_inc(
    input bcd_t tens,
    input bcd_t ones
  );
    if (ones != BCD_MAX)
      return {tens, ones + 4'd1};
    else if (tens != BCD_MAX)
      return {tens + 4'd1, 4'd0};
    else
      return {tens, ones};
  endfunction

endpackage

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD up counter with synchronous clear.
// Clear has priority over increment; the pair holds at 99.
module bcd_pair_counter
  import pong_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output bcd_t tens,
  output bcd_t ones
);

  // Digit pair register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens <= '0;
      ones <= '0;
    end else if (clr) begin
      tens <= '0;
      ones <= '0;
    end else if (inc) begin
      {tens, ones} <= bcd_inc(tens, ones);
    end
  end

endmodule

// File: rtl/pong_score_keeper.sv
// Pong score keeper: two BCD score pairs, win detect, game-over hold.
// Optional winner blink on digit_en when SCORE_BLINK_EN is defined.
module pong_score_keeper
  import pong_pkg::*;
#(
  parameter int WIN_SCORE = 11,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       point_l,
  input  logic       point_r,
  input  logic       new_game,
  output logic [3:0] l_tens,
  output logic [3:0] l_ones,
  output logic [3:0] r_tens,
  output logic [3:0] r_ones,
  output logic       game_over,
  output logic       winner,
  output logic [3:0] digit_en
);

  localparam bcd_t WIN_TENS = bcd_t'(WIN_SCORE / 10);
  localparam bcd_t WIN_ONES = bcd_t'(WIN_SCORE % 10);

  if (WIN_SCORE < 1 || WIN_SCORE > 99 || BLINK_DIV < 1) begin : g_bad_cfg
    $error("pong_score_keeper: bad WIN_SCORE or BLINK_DIV");
  end

  game_state_t state;
  game_state_t state_nxt;

  logic       play;
  logic       inc_l;
  logic       inc_r;
  logic       win_l;
  logic       win_r;
  logic [7:0] nxt_l;
  logic [7:0] nxt_r;

  assign play = (state == PLAY);

  // Point arbitration: new_game, then left, then right.
  always_comb begin
    inc_l = 1'b0;
    inc_r = 1'b0;
    unique case (1'b1)
      new_game: ;
      (!new_game && play && point_l):
        inc_l = 1'b1;
      (!new_game && play && !point_l && point_r):
        inc_r = 1'b1;
      default: ;
    endcase
  end

  bcd_pair_counter u_left (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (new_game),
    .inc   (inc_l),
    .tens  (l_tens),
    .ones  (l_ones)
  );

  bcd_pair_counter u_right (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (new_game),
    .inc   (inc_r),
    .tens  (r_tens),
    .ones  (r_ones)
  );

  // Win compare on the post-increment score, digit by digit.
  always_comb begin
    nxt_l = bcd_inc(l_tens, l_ones);
    nxt_r = bcd_inc(r_tens, r_ones);
    win_l = inc_l && (nxt_l == {WIN_TENS, WIN_ONES});
    win_r = inc_r && (nxt_r == {WIN_TENS, WIN_ONES});
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= PLAY;
    else
      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      PLAY: if (win_l || win_r) state_nxt = OVER;
      OVER: if (new_game) state_nxt = PLAY;
      default: state_nxt = PLAY;
    endcase
  end

  // Winner latches the scoring side on the winning edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      winner <= 1'b0;
    else if (win_l)
      winner <= 1'b0;
    else if (win_r)
      winner <= 1'b1;
  end

`ifdef SCORE_BLINK_EN
  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          phase;

  // Blink phase counter; parked lit while playing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (play) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Outputs: game_over from state, winner's digits follow phase.
  always_comb begin
    game_over = (state == OVER);
    digit_en  = 4'hF;
    if (state == OVER) begin
      if (winner)
        digit_en[1:0] = {2{phase}};
      else
        digit_en[3:2] = {2{phase}};
    end
  end
`else
  // Outputs: game_over from state, all digits always lit.
  always_comb begin
    game_over = (state == OVER);
    digit_en  = 4'hF;
  end
`endif

endmodule

// File: tb/tb_pong_score_keeper.sv
// Scoreboard bench for pong_score_keeper (WIN_SCORE=11, BLINK_DIV=4).
// Stimulus pushes expected outputs; a monitor pops and compares.
module tb_pong_score_keeper;

  logic       clk;
  logic       rst_n;
  logic       point_l;
  logic       point_r;
  logic       new_game;
  logic [3:0] l_tens;
  logic [3:0] l_ones;
  logic [3:0] r_tens;
  logic [3:0] r_ones;
  logic       game_over;
  logic       winner;
  logic [3:0] digit_en;

  typedef struct {
    logic [7:0] l;
    logic [7:0] r;
    logic       go;
    logic       wchk;
    logic       w;
    logic [3:0] den;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  pong_score_keeper #(
    .WIN_SCORE (11),
    .BLINK_DIV (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .point_l   (point_l),
    .point_r   (point_r),
    .new_game  (new_game),
    .l_tens    (l_tens),
    .l_ones    (l_ones),
    .r_tens    (r_tens),
    .r_ones    (r_ones),
    .game_over (game_over),
    .winner    (winner),
    .digit_en  (digit_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  // k = edges since entering OVER; w = winning side.
  function automatic logic [3:0] blink_den(input int k, input logic w);
`ifdef SCORE_BLINK_EN
    if (((k / 4) % 2) == 1)
      return w ? 4'hC : 4'h3;
`endif
    return 4'hF;
  endfunction

  task automatic push(
    input int l, input int r, input logic go,
    input logic wchk, input logic w,
    input logic [3:0] den, input string nm
  );
    exp_t e;
    e.l = bcd(l);
    e.r = bcd(r);
    e.go = go;
    e.wchk = wchk;
    e.w = w;
    e.den = den;
    e.nm = nm;
    q.push_back(e);
  endtask

  task automatic step(
    input logic pl, input logic pr, input logic ng,
    input int l, input int r, input logic go,
    input logic wchk, input logic w,
    input logic [3:0] den, input string nm
  );
    @(negedge clk);
    point_l = pl;
    point_r = pr;
    new_game = ng;
    push(l, r, go, wchk, w, den, nm);
  endtask

  // Monitor: compare after every clock edge or async reset.
  initial begin
    exp_t e;
    logic ok;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        ok = ({l_tens, l_ones} == e.l) &&
             ({r_tens, r_ones} == e.r) &&
             (game_over == e.go) &&
             (digit_en == e.den) &&
             (!e.wchk || (winner == e.w));
        checks++;
        if (!ok) begin
          failures++;
          $display("FAIL %s: got l=%h r=%h go=%b w=%b en=%h, want l=%h r=%h go=%b w=%b(chk %b) en=%h",
                   e.nm, {l_tens, l_ones}, {r_tens, r_ones},
                   game_over, winner, digit_en,
                   e.l, e.r, e.go, e.w, e.wchk, e.den);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    point_l = 1'b0;
    point_r = 1'b0;
    new_game = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;

    step(0, 0, 0, 0, 0, 0, 1, 0, 4'hF, "reset_state");
    for (int i = 1; i <= 7; i++)
      step(1, 0, 0, i, 0, 0, 0, 0, 4'hF, "count_l");

    // Asynchronous reset mid-count, checked before any clock edge.
    @(negedge clk);
    point_l = 1'b1;
    push(0, 0, 0, 1, 0, 4'hF, "async_reset");
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    point_l = 1'b0;
    rst_n = 1'b1;

    for (int i = 1; i <= 10; i++)
      step(1, 0, 0, i, 0, 0, 0, 0, 4'hF, "carry_l");
    step(0, 0, 1, 0, 0, 0, 0, 0, 4'hF, "new_game_play");

    for (int i = 1; i <= 3; i++)
      step(1, 0, 0, i, 0, 0, 0, 0, 4'hF, "pre_collide_l");
    for (int i = 1; i <= 4; i++)
      step(0, 1, 0, 3, i, 0, 0, 0, 4'hF, "pre_collide_r");
    step(1, 1, 0, 4, 4, 0, 0, 0, 4'hF, "collide");
    step(1, 0, 1, 0, 0, 0, 0, 0, 4'hF, "ng_beats_point");

    for (int i = 1; i <= 10; i++)
      step(0, 1, 0, 0, i, 0, 0, 0, 4'hF, "run_r");
    step(0, 1, 0, 0, 11, 1, 1, 1, blink_den(0, 1), "win_r");
    for (int k = 1; k <= 7; k++)
      step(k == 1, k == 2, 0, 0, 11, 1, 1, 1,
           blink_den(k, 1), "over_frozen");
    step(0, 0, 1, 0, 0, 0, 0, 0, 4'hF, "restart");
    step(1, 0, 0, 1, 0, 0, 0, 0, 4'hF, "after_restart");

    for (int i = 2; i <= 10; i++)
      step(1, 0, 0, i, 0, 0, 0, 0, 4'hF, "run_l");
    step(1, 0, 0, 11, 0, 1, 1, 0, blink_den(0, 0), "win_l");
    for (int k = 1; k <= 8; k++)
      step(0, 0, 0, 11, 0, 1, 1, 0, blink_den(k, 0), "blink_l");
    step(0, 0, 1, 0, 0, 0, 0, 0, 4'hF, "ng_unblink");

    @(negedge clk);
    point_l = 1'b0;
    point_r = 1'b0;
    new_game = 1'b0;
    repeat (3) @(negedge clk);

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
